// File: rtl/idli_decq_m.sv
// Decode queue: assembles 16-bit words from serial slices, binds inline-immediate
// instructions to their following word, and buffers DEPTH complete entries.
module idli_decq_m #(
   parameter int SLICE_W = 4,
   parameter int DEPTH   = 2
) (
   input  logic                     i_dq_gck,
   input  logic                     i_dq_rst,
   input  logic [SLICE_W-1:0]       i_dq_slice,
   input  logic                     i_dq_slice_vld,
   output logic                     o_dq_in_rdy,
   input  logic                     i_dq_flush,
   output logic                     o_dq_vld,
   input  logic                     i_dq_rdy,
   output logic [15:0]              o_dq_enc,
   output logic [15:0]              o_dq_imm,
   output logic                     o_dq_has_imm,
   output logic [$clog2(DEPTH):0]   o_dq_cnt
);

   localparam int SPW = 16 / SLICE_W;
   localparam int KW  = (SPW > 1) ? $clog2(SPW) : 1;
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;

   localparam logic [KW-1:0] K_LAST   = KW'(SPW - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef struct packed {
      logic [15:0] enc;
      logic [15:0] imm;
      logic        has_imm;
      logic        cmp;
   } slot_t;

   slot_t          slot_q [DEPTH];
   slot_t          slot_d [DEPTH];
   logic [15:0]    word_q, word_d;
   logic [15:0]    asm_word;
   logic [KW-1:0]  k_q, k_d;
   logic           pend_q, pend_d;
   logic [PW-1:0]  wr_q, wr_d;
   logic [PW-1:0]  rd_q, rd_d;
   logic [PW-1:0]  last_ptr;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic           accept;
   logic           word_done;
   logic           push;
   logic           fill_imm;
   logic           pop;
   logic           new_needs_imm;

   // LDM/STM and URX/GETP reuse C = 4'hF for other purposes and never take an immediate.
   function automatic logic needs_imm(input logic [15:0] enc);
      return (enc[15:12] == 4'hF)
          && (enc[3:1] != 3'b100)
          && !((enc[3:0] == 4'b1101) && !enc[8]);
   endfunction

   // An immediate always fits: its slot was allocated with the instruction.
   assign o_dq_in_rdy  = (cnt_q < CNT_FULL) || pend_q;
   assign o_dq_vld     = (cnt_q != '0) && slot_q[rd_q].cmp;
   assign o_dq_enc     = slot_q[rd_q].enc;
   assign o_dq_imm     = slot_q[rd_q].imm;
   assign o_dq_has_imm = slot_q[rd_q].has_imm;
   assign o_dq_cnt     = cnt_q;

   assign accept        = i_dq_slice_vld && o_dq_in_rdy && !i_dq_flush;
   assign word_done     = accept && (k_q == K_LAST);
   assign push          = word_done && !pend_q;
   assign fill_imm      = word_done && pend_q;
   assign pop           = o_dq_vld && i_dq_rdy && !i_dq_flush;
   assign last_ptr      = wr_q - PW'(1);
   assign new_needs_imm = needs_imm(asm_word);

   // Current word with the incoming slice merged at position k.
   always_comb begin
      asm_word = word_q;
      asm_word[int'(k_q) * SLICE_W +: SLICE_W] = i_dq_slice;
   end

   always_comb begin
      // NOTE: every variable gets a default up front so no path leaves it unassigned (no latches).
      slot_d = slot_q;
      word_d = word_q;
      k_d    = k_q;
      pend_d = pend_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;

      if (i_dq_flush) begin
         k_d    = '0;
         pend_d = 1'b0;
         wr_d   = '0;
         rd_d   = '0;
         cnt_d  = '0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_d[i].cmp = 1'b0;
         end
      end else begin
         if (accept) begin
            word_d = asm_word;
            k_d    = (k_q == K_LAST) ? '0 : k_q + KW'(1);
         end

         if (push) begin
            slot_d[wr_q] = '{enc: asm_word, imm: 16'h0000,
                             has_imm: new_needs_imm, cmp: !new_needs_imm};
            wr_d   = wr_q + PW'(1);
            pend_d = new_needs_imm;
         end else if (fill_imm) begin
            slot_d[last_ptr].imm = asm_word;
            slot_d[last_ptr].cmp = 1'b1;
            pend_d               = 1'b0;
         end

         if (pop) begin
            rd_d = rd_q + PW'(1);
         end

         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge i_dq_gck) begin
      if (i_dq_rst) begin
         // NOTE: slot storage is cleared too, so the head outputs read zero straight after reset.
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
         word_q <= '0;
         k_q    <= '0;
         pend_q <= 1'b0;
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples the same pre-edge state.
         slot_q <= slot_d;
         word_q <= word_d;
         k_q    <= k_d;
         pend_q <= pend_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: doc/idli_decq_m.md
# idli_decq_m

Parametrised decode queue between the SQI fetch path and the instruction decoder. It assembles instruction words from narrow serial slices of configurable width and detects instructions whose RHS is an inline immediate (C field = 4'hF). It binds each such instruction to the immediate word that follows it and buffers up to DEPTH complete entries with a valid/ready handshake. Branch redirects flush it.

## Interface
- SLICE_W, 4: bits accepted per slice; legal values 1, 2, 4, 8, 16. One word takes SPW = 16/SLICE_W slices.
- DEPTH, 2: entries held; a power of two, at least 2.
- i_dq_gck  in  1  clock.
- i_dq_rst  in  1  reset; synchronous, active-high.
- i_dq_slice  in  SLICE_W  next slice of the current word, least-significant first.
- i_dq_slice_vld  in  1  slice valid.
- o_dq_in_rdy  out  1  slice accepted when vld && in_rdy.
- i_dq_flush  in  1  discard all entries and any partial word.
- o_dq_vld  out  1  head entry complete.
- i_dq_rdy  in  1  consumer pops head when vld && rdy.
- o_dq_enc  out  16  head instruction encoding.
- o_dq_imm  out  16  head immediate; 0 when the instruction has no immediate.
- o_dq_has_imm  out  1  head carries an immediate.
- o_dq_cnt  out  $clog2(DEPTH)+1  allocated entries, including a pending one.

## Operation
- Field layout: opcode = enc[3:0], A = enc[7:4], B = enc[11:8], C = enc[15:12].
- Assembler: a shift register plus a slice counter (0..SPW-1, wrapping).
  - Each accepted slice lands at bits [k*SLICE_W +: SLICE_W], where k is the counter value.
  - The word completes on the cycle the slice with k = SPW-1 is accepted.
- Completed word, case 1: pend = 0 (the word is an instruction).
  - Allocate slot wr_ptr: store enc, clear imm, set has_imm = needs_imm(enc).
  - cnt increments and wr_ptr advances.
  - If has_imm = 1, set pend = 1 and the slot stays incomplete.
  - Otherwise the slot is marked complete.
- Completed word, case 2: pend = 1 (the word is an immediate).
  - Write it to the imm field of the most recently allocated slot.
  - Mark that slot complete and clear pend.
  - cnt and wr_ptr are unchanged.
- needs_imm(enc) = (C == 4'hF) && !(opcode[3:1] == 3'b100) && !(opcode == 4'b1101 && enc[8] == 0).
  - The exclusions are LDM/STM and URX/GETP, which never take an immediate.
- o_dq_in_rdy = (cnt < DEPTH) || pend. An immediate never needs a new slot.
- o_dq_vld = (cnt != 0) && slot[rd_ptr].complete.
- Pop: rd_ptr advances and cnt decrements.
- Push and pop in the same cycle: cnt is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- Flush:
  - Clears cnt, both pointers, pend, the slice counter and all complete bits.
  - A slice or pop presented in the same cycle is ignored.
  - Flush has priority over every other event.
- Reset: same effect as flush, and storage is also zeroed.

## Timing
- Outputs after the reset cycle: o_dq_vld = 0, o_dq_cnt = 0, o_dq_in_rdy = 1, o_dq_enc = 0, o_dq_imm = 0, o_dq_has_imm = 0.
- Reset mid-word: the partial word is lost and assembly restarts at k = 0.
- Latency: an entry is visible on o_dq_vld the cycle after its final slice (the instruction's, or the immediate's) is accepted.
- Minimum cost: an entry takes SPW accepted slices without an immediate, 2·SPW with one.
- Head outputs are registered state. They are stable while vld && !rdy.
- o_dq_in_rdy is combinational from registered state only; it does not depend on i_dq_slice_vld or i_dq_rdy. A pop in cycle n therefore raises in_rdy in cycle n+1.
- Full (cnt = DEPTH, pend = 0): in_rdy = 0 and i_dq_slice is ignored, even when a pop occurs in the same cycle.
- Pending immediate at head: o_dq_vld = 0 until the immediate completes, even if later slots are complete. Slots complete in order, so this case only arises at the head.

## Test plan
- SLICE_W=4, DEPTH=2; slices 0x8,0x1,0x2,0x3 (enc 0x3218) -> o_dq_vld=1 the next cycle, enc=0x3218, has_imm=0, cnt=1.
- SLICE_W=4; slices 0x0,0x1,0x2,0xF then 0xF,0xE,0xE,0xB -> vld stays 0 through the first word; then enc=0xF210, imm=0xBEEF, has_imm=1, cnt=1 throughout.
- LDM with C=F (enc 0xF218) followed by 0x3218 -> two entries, both has_imm=0; the second word is treated as an instruction.
- DEPTH=2, i_dq_rdy=0, three back-to-back words -> after two words, in_rdy=0 and cnt=2. The third word's slices are ignored until one pop; in_rdy rises the following cycle.
- Flush after 2 of 4 slices of an immediate -> cnt=0, vld=0, pend=0. A new 0x3218 then decodes as an instruction.
- SLICE_W=1, DEPTH=4; 9 words with pops interleaved so pointers wrap twice -> entries pop in order with correct encodings; simultaneous push/pop leaves cnt unchanged.
